// File: rtl/aoc_pkg.sv
// Shared character constants and stream FSM encoding for the AoC input front end.
package aoc_pkg;
  localparam logic [7:0] CH_NL = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    STREAM,
    FLUSH,
    DRAIN,
    FINISH,
    DONE
  } strm_state_t;
endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO. The head entry is always presented from storage registers,
// so the consumer can inspect a byte before deciding to pop it.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/aoc_byte_streamer.sv
// Puzzle-file byte front end: buffers source bytes, drops CR, holds back newlines
// and emits a gap-paced, end-terminated byte stream to the solver.
//
// state  | meaning
// STREAM | pop FIFO head; emit data, count newlines into nl_pend
// FLUSH  | emit pending newlines, then the held data byte
// DRAIN  | end of file: emit pending trailing newlines
// FINISH | wait for gap, pulse read_val_done
// DONE   | idle until reset
module aoc_byte_streamer
  import aoc_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int GAP            = 0,
  parameter bit STRIP_TRAIL_NL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  read_val,
  output logic        read_val_valid,
  output logic        read_val_done,
  output logic [31:0] byte_count
);
  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  strm_state_t   state, state_d;
  logic          eof_seen;
  logic [7:0]    nl_pend, nl_pend_d;
  logic [7:0]    hold_byte, hold_d;
  logic [GW-1:0] gap_cnt;
  logic          gap_ok;
  logic          accept, pop;
  logic          emit, done_d;
  logic [7:0]    emit_byte;
  logic [7:0]    head;
  logic          fifo_full, fifo_empty;

  assign in_ready = !fifo_full && !eof_seen;
  assign accept   = in_valid && in_ready;
  assign gap_ok   = (gap_cnt == '0);

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && (in_data != CH_CR)),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= STREAM;
      eof_seen       <= 1'b0;
      nl_pend        <= '0;
      hold_byte      <= '0;
      gap_cnt        <= '0;
      read_val       <= '0;
      read_val_valid <= 1'b0;
      read_val_done  <= 1'b0;
      byte_count     <= '0;
    end else begin
      state          <= state_d;
      nl_pend        <= nl_pend_d;
      hold_byte      <= hold_d;
      read_val_valid <= emit;
      read_val_done  <= done_d;
      if (accept && in_last) eof_seen <= 1'b1;
      // Down-counter reloads on every beat; zero is the terminal count that permits the next one.
      if (emit) gap_cnt <= GW'(GAP);
      else if (!gap_ok) gap_cnt <= gap_cnt - GW'(1);
      if (emit) begin
        read_val   <= emit_byte;
        byte_count <= byte_count + 32'd1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    nl_pend_d = nl_pend;
    hold_d    = hold_byte;
    pop       = 1'b0;
    case (state)
      STREAM: begin
        if (!fifo_empty) begin
          if (gap_ok) begin
            pop = 1'b1;
            if (head == CH_NL) begin
              if (nl_pend != 8'hFF) nl_pend_d = nl_pend + 8'd1;
            end else if (nl_pend != 8'd0) begin
              hold_d  = head;
              state_d = FLUSH;
            end
          end
        end else if (eof_seen) begin
          if ((nl_pend != 8'd0) && !STRIP_TRAIL_NL) begin
            state_d = DRAIN;
          end else begin
            nl_pend_d = '0;
            state_d   = FINISH;
          end
        end
      end
      FLUSH: begin
        if (gap_ok) begin
          if (nl_pend != 8'd0) nl_pend_d = nl_pend - 8'd1;
          else state_d = STREAM;
        end
      end
      DRAIN: begin
        if (nl_pend == 8'd0) state_d = FINISH;
        else if (gap_ok) nl_pend_d = nl_pend - 8'd1;
      end
      FINISH:  if (gap_ok) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = STREAM;
    endcase
  end

  always_comb begin
    emit      = 1'b0;
    emit_byte = read_val;
    done_d    = 1'b0;
    case (state)
      STREAM: begin
        if (!fifo_empty && gap_ok && (head != CH_NL) && (nl_pend == 8'd0)) begin
          emit      = 1'b1;
          emit_byte = head;
        end
      end
      FLUSH: begin
        if (gap_ok) begin
          emit      = 1'b1;
          emit_byte = (nl_pend != 8'd0) ? CH_NL : hold_byte;
        end
      end
      DRAIN: begin
        if (gap_ok && (nl_pend != 8'd0)) begin
          emit      = 1'b1;
          emit_byte = CH_NL;
        end
      end
      FINISH:  done_d = gap_ok;
      default: ;
    endcase
  end
endmodule
